// File: rtl/pixel_fetch_ctrl_if.sv
// Memory read port and pixel_concat word stream of pixel_fetch_ctrl.
// master = fetch controller, slave = memory / pixel_concat side.
interface pixel_fetch_ctrl_if #(
  parameter int unsigned DAT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DAT_WIDTH-1:0]  mem_rdata;
  logic [DAT_WIDTH-1:0]  idat;
  logic                  ival;
  logic                  ostall;
  logic                  oval;

  modport master (
    output mem_ren, mem_raddr, idat, ival,
    input  mem_rdata, ostall, oval
  );

  modport slave (
    input  mem_ren, mem_raddr, idat, ival,
    output mem_rdata, ostall, oval
  );
endinterface

// File: rtl/pixel_fetch_ctrl.sv
// Frame-fetch sequencer: streams a run of packed words from memory to pixel_concat
// and counts emitted pixels. Optional drain watchdog: define PIXEL_FETCH_TIMEOUT_EN.
module pixel_fetch_ctrl #(
  parameter int unsigned DAT_WIDTH    = 32,
  parameter int unsigned PIX_WIDTH    = 24,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH    = 20,
  parameter int unsigned TIMEOUT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  pix_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  pixel_fetch_ctrl_if.master    bus
);

  localparam int unsigned PROD_W = CNT_WIDTH + $clog2(PIX_WIDTH + 1) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_WIDTH-1:0]    pix_num_q, pix_num_d;
  logic [CNT_WIDTH-1:0]    words_total_q, words_total_d;
  logic [CNT_WIDTH-1:0]    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]    pix_seen_q, pix_seen_d;
  logic [DAT_WIDTH-1:0]    q_mem_q [2];
  logic [DAT_WIDTH-1:0]    q_mem_d [2];
  logic                    head_q, head_d;
  logic [1:0]              count_q, count_d;
  logic                    inflight_q, inflight_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    stored_ne;
  logic                    ival_c;
  logic                    pop_stored;
  logic                    push;
  logic                    ren_c;
  logic [DAT_WIDTH-1:0]    idat_c;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    pix_num_d     = pix_num_q;
    words_total_d = words_total_q;
    issued_d      = issued_q;
    pix_seen_d    = pix_seen_q;
    q_mem_d       = q_mem_q;
    head_d        = head_q;
    count_d       = count_q;
    wd_d          = '0;
    err_d         = err_q;

    // A word returning from memory is visible the same cycle: it bypasses the
    // queue when nothing is stored, otherwise it is parked behind the head.
    stored_ne  = (count_q != 2'd0);
    ival_c     = (stored_ne | inflight_q) & ~bus.ostall;
    idat_c     = stored_ne ? q_mem_q[head_q] : (inflight_q ? bus.mem_rdata : '0);
    pop_stored = ival_c & stored_ne;
    push       = inflight_q & ~(ival_c & ~stored_ne);

    ren_c = (state_q == FETCH) && !bus.ostall && (issued_q < words_total_q) &&
            ((count_q + 2'(inflight_q)) < 2'd2);
    inflight_d = ren_c;
    if (ren_c) issued_d = issued_q + CNT_WIDTH'(1);

    if (push) q_mem_d[head_q ^ count_q[0]] = bus.mem_rdata;
    if (pop_stored) head_d = ~head_q;
    count_d = count_q + 2'(push) - 2'(pop_stored);

    if ((state_q == FETCH || state_q == DRAIN) && bus.oval && (pix_seen_q != pix_num_q))
      pix_seen_d = pix_seen_q + CNT_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          pix_num_d  = pix_num;
          issued_d   = '0;
          pix_seen_d = '0;
          err_d      = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        words_total_d = CNT_WIDTH'((PROD_W'(pix_num_q) * PROD_W'(PIX_WIDTH) +
                                    PROD_W'(DAT_WIDTH - 1)) / PROD_W'(DAT_WIDTH));
        state_d = (pix_num_q == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (issued_q == words_total_q) state_d = DRAIN;
      end
      DRAIN: begin
        wd_d = bus.oval ? '0 : wd_q + TIMEOUT_BITS'(1);
        if (pix_seen_d == pix_num_q && count_d == 2'd0) state_d = DONE;
`ifdef PIXEL_FETCH_TIMEOUT_EN
        else if (wd_q == '1) begin
          count_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      pix_num_q     <= '0;
      words_total_q <= '0;
      issued_q      <= '0;
      pix_seen_q    <= '0;
      q_mem_q       <= '{default: '0};
      head_q        <= 1'b0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      pix_num_q     <= pix_num_d;
      words_total_q <= words_total_d;
      issued_q      <= issued_d;
      pix_seen_q    <= pix_seen_d;
      q_mem_q       <= q_mem_d;
      head_q        <= head_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      wd_q          <= wd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.mem_ren   = ren_c;
  assign bus.mem_raddr = base_q + ADDR_WIDTH'(issued_q);
  assign bus.ival      = ival_c;
  assign bus.idat      = idat_c;

endmodule
